// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract unit.
// The master side issues requests; the slave side is the serial adder.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carryOut;
    logic             overflow;

    modport master (
        output start, sub, a, b, carryIn,
        input  busy, done, sum, carryOut, overflow
    );

    modport slave (
        input  start, sub, a, b, carryIn,
        output busy, done, sum, carryOut, overflow
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract unit: one full adder reused for every bit,
// LSB first, with the carry held in a flop between cycles.
module fullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rstN,
    serial_adder_ctrl_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry_out;
    logic               r_overflow;

    state_t             w_state_next;
    logic [WIDTH-1:0]   w_opa_next;
    logic [WIDTH-1:0]   w_opb_next;
    logic               w_carry_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [WIDTH-1:0]   w_sum_next;
    logic               w_carry_out_next;
    logic               w_overflow_next;

    logic               w_fa_sum;
    logic               w_fa_cout;

    // The single shared adder always looks at the current LSBs and held carry.
    fullAdder u_fa (
        .i_a    (r_opa[0]),
        .i_b    (r_opb[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state     <= IDLE;
            r_opa       <= '0;
            r_opb       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_opa       <= w_opa_next;
            r_opb       <= w_opb_next;
            r_carry     <= w_carry_next;
            r_cnt       <= w_cnt_next;
            r_sum       <= w_sum_next;
            r_carry_out <= w_carry_out_next;
            r_overflow  <= w_overflow_next;
        end
    end

    // Next-state and datapath update: load on start, one bit per SHIFT cycle.
    always_comb begin
        w_state_next     = r_state;
        w_opa_next       = r_opa;
        w_opb_next       = r_opb;
        w_carry_next     = r_carry;
        w_cnt_next       = r_cnt;
        w_sum_next       = r_sum;
        w_carry_out_next = r_carry_out;
        w_overflow_next  = r_overflow;

        case (r_state)
            IDLE: begin
                // Inputs are only looked at when start is high, so idle X's
                // on the operand lines never reach the registers.
                if (bus.start) begin
                    w_state_next     = SHIFT;
                    w_opa_next       = bus.a;
                    w_opb_next       = bus.sub ? ~bus.b : bus.b;
                    w_carry_next     = bus.sub ? 1'b1 : bus.carryIn;
                    w_cnt_next       = '0;
                    w_sum_next       = '0;
                    w_carry_out_next = 1'b0;
                    w_overflow_next  = 1'b0;
                end
            end
            SHIFT: begin
                w_sum_next   = {w_fa_sum, r_sum[WIDTH-1:1]};
                w_opa_next   = r_opa >> 1;
                w_opb_next   = r_opb >> 1;
                w_carry_next = w_fa_cout;
                w_cnt_next   = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_BIT) begin
                    // r_carry is the carry into the MSB at this point.
                    w_state_next     = DONE;
                    w_carry_out_next = w_fa_cout;
                    w_overflow_next  = r_carry ^ w_fa_cout;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = (r_state == DONE);
    assign bus.sum      = r_sum;
    assign bus.carryOut = r_carry_out;
    assign bus.overflow = r_overflow;
endmodule
